// File: rtl/riscv_pkg.sv
// Shared integer-core definitions: data width, register-file geometry and
// the write-back request record used by the register-file write path.
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] waddr;
      logic [XLEN-1:0]   wdata;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over a request vector, searching upward
// from a rotating pointer that moves to just past the most recent winner.
//
// Handshake: requester i is granted when req_i[i] and gnt_o[i] are both high in
// the same cycle; gnt_o[i] is never high without req_i[i], and at most one
// grant is high at a time.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o,
   output logic         gnt_any_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic [PW-1:0] win;

   always_comb begin
      int idx;
      gnt_o     = '0;
      gnt_any_o = 1'b0;
      win       = '0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_q) + k) % N;
         if (!gnt_any_o && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            gnt_any_o  = 1'b1;
            win        = PW'(idx);
         end
      end
   end

   // Pointer only rotates on an actual grant, so idle cycles keep fairness.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any_o) begin
         ptr_d = (win == PW'(N - 1)) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler: arbitrates requesters onto the single register-file
// write port and keeps a per-register busy scoreboard for RAW/WAW detection.
module rf_wb_scheduler #(
   parameter int NREQ = 3,
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NREQ-1:0]                  req_valid,
   input  logic [NREQ*riscv_pkg::REG_AW-1:0] req_waddr,
   input  logic [NREQ*XLEN-1:0]             req_wdata,
   output logic [NREQ-1:0]                  req_ready,
   input  logic                             rsv_valid,
   input  logic [riscv_pkg::REG_AW-1:0]     rsv_addr,
   output logic                             rsv_ok,
   input  logic [riscv_pkg::REG_AW-1:0]     chk_addr1,
   input  logic [riscv_pkg::REG_AW-1:0]     chk_addr2,
   output logic                             hazard1,
   output logic                             hazard2,
   output logic                             rf_we,
   output logic [riscv_pkg::REG_AW-1:0]     rf_waddr,
   output logic [XLEN-1:0]                  rf_wdata,
   output logic [riscv_pkg::NREG-1:0]       busy_o
);

   import riscv_pkg::*;

   logic [NREQ-1:0]   gnt;
   logic              gnt_any;
   logic [REG_AW-1:0] win_addr;
   logic [XLEN-1:0]   win_data;

   logic              rf_we_q,    rf_we_d;
   logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
   logic [NREG-1:0]   busy_q,     busy_d;

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_valid),
      .gnt_o     (gnt),
      .gnt_any_o (gnt_any)
   );

   assign req_ready = gnt;

   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            win_addr = req_waddr[i*REG_AW +: REG_AW];
            win_data = req_wdata[i*XLEN +: XLEN];
         end
      end
   end

   // A write to x0 is consumed but never reaches the register file.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (gnt_any) begin
         rf_we_d    = (win_addr != '0);
         rf_waddr_d = win_addr;
         rf_wdata_d = win_data;
      end
   end

   assign rsv_ok  = (rsv_addr == '0) || !busy_q[rsv_addr];
   assign hazard1 = busy_q[chk_addr1];
   assign hazard2 = busy_q[chk_addr2];

   // Clear lands on the register-file commit edge; set and clear never hit
   // the same register because a busy register refuses reservation.
   always_comb begin
      busy_d = busy_q;
      if (rf_we_q) begin
         busy_d[rf_waddr_q] = 1'b0;
      end
      if (rsv_valid && rsv_ok && (rsv_addr != '0)) begin
         busy_d[rsv_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign busy_o   = busy_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: directed scenarios then random traffic, all
// checked against a behavioural model of arbitration, output and scoreboard.
module tb_rf_wb_scheduler;
   import riscv_pkg::*;

   localparam int NREQ = 3;

   logic                   clk;
   logic                   rst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*REG_AW-1:0] req_waddr;
   logic [NREQ*XLEN-1:0]   req_wdata;
   logic [NREQ-1:0]        req_ready;
   logic                   rsv_valid;
   logic [REG_AW-1:0]      rsv_addr;
   logic                   rsv_ok;
   logic [REG_AW-1:0]      chk_addr1;
   logic [REG_AW-1:0]      chk_addr2;
   logic                   hazard1;
   logic                   hazard2;
   logic                   rf_we;
   logic [REG_AW-1:0]      rf_waddr;
   logic [XLEN-1:0]        rf_wdata;
   logic [NREG-1:0]        busy_o;

   rf_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_waddr (req_waddr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .rsv_ok    (rsv_ok),
      .chk_addr1 (chk_addr1),
      .chk_addr2 (chk_addr2),
      .hazard1   (hazard1),
      .hazard2   (hazard2),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .busy_o    (busy_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file as the consumer sees it.
   logic [XLEN-1:0] tb_rf [NREG];
   always @(posedge clk) begin
      if (rf_we) tb_rf[rf_waddr] <= rf_wdata;
   end

   // ---------------- model state / scoreboard ----------------
   int              total;
   int              bad;
   int              m_ptr;
   logic            m_we;
   logic [REG_AW-1:0] m_waddr;
   logic [XLEN-1:0] m_wdata;
   logic [NREG-1:0] m_busy;
   wb_req_t         exp_q[$];
   int              last_g;
   bit              auto_refill;
   logic [NREG-1:0] saved_busy;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic present(input int i, input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d);
      req_valid[i]                = 1'b1;
      req_waddr[i*REG_AW +: REG_AW] = a;
      req_wdata[i*XLEN +: XLEN]     = d;
   endtask

   task automatic present_rand(input int i);
      present(i, REG_AW'($urandom_range(0, 7)), $urandom);
   endtask

   // One clock: check combinational outputs against the model, advance the
   // model across the edge, then check the registered outputs.
   task automatic cycle();
      int              g;
      logic            ok;
      logic [NREG-1:0] nb;
      logic [NREQ-1:0] exp_rdy;
      bit              was_rst;
      wb_req_t         w;
      #1;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         int idx = (m_ptr + k) % NREQ;
         if (g < 0 && req_valid[idx]) g = idx;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      ok = (rsv_addr == 0) || !m_busy[rsv_addr];
      check_eq("ready", req_ready, exp_rdy);
      check_eq("rsv_ok", rsv_ok, ok);
      check_eq("hazard1", hazard1, (chk_addr1 != 0) && m_busy[chk_addr1]);
      check_eq("hazard2", hazard2, (chk_addr2 != 0) && m_busy[chk_addr2]);
      was_rst = rst;
      if (rst) begin
         m_ptr = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_busy = '0;
         exp_q.delete();
      end else begin
         nb = m_busy;
         if (m_we) nb[m_waddr] = 1'b0;
         if (rsv_valid && ok && rsv_addr != 0) nb[rsv_addr] = 1'b1;
         m_busy = nb;
         m_we = 1'b0;
         if (g >= 0) begin
            w.waddr = req_waddr[g*REG_AW +: REG_AW];
            w.wdata = req_wdata[g*XLEN +: XLEN];
            exp_q.push_back(w);
            m_ptr = (g + 1) % NREQ;
         end
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         w = exp_q.pop_front();
         m_we    = (w.waddr != 0);
         m_waddr = w.waddr;
         m_wdata = w.wdata;
      end
      check_eq("rf_we", rf_we, m_we);
      check_eq("rf_waddr", rf_waddr, m_waddr);
      check_eq("rf_wdata", rf_wdata, m_wdata);
      check_eq("busy", busy_o, m_busy);
      last_g = -1;
      if (!was_rst && g >= 0) begin
         last_g = g;
         if (auto_refill) present_rand(g);
         else req_valid[g] = 1'b0;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      total = 0; bad = 0; last_g = -1; auto_refill = 0;
      rst = 1'b1; req_valid = '0; req_waddr = '0; req_wdata = '0;
      rsv_valid = 1'b0; rsv_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
      for (int r = 0; r < NREG; r++) tb_rf[r] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_ptr = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_busy = '0;

      // Reset state and idle
      check_eq("rst_we", rf_we, 0);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_ready", req_ready, 0);
      repeat (3) cycle();

      // All requesters continuously valid: strict 0,1,2 rotation
      auto_refill = 1;
      for (int i = 0; i < NREQ; i++) present(i, REG_AW'(10 + i), 32'h100 + i);
      for (int k = 0; k < 6; k++) begin
         cycle();
         check_eq("gseq", last_g, k % NREQ);
      end
      auto_refill = 0;
      req_valid = '0;
      cycle();

      // Reserve x5, write it two cycles later, watch the hazard drop
      chk_addr1 = 5;
      rsv_valid = 1; rsv_addr = 5; cycle();
      rsv_valid = 0; cycle();
      present(1, 5, 32'hDEADBEEF); cycle();
      check_eq("x5_gnt", last_g, 1);
      check_eq("x5_haz_inflight", hazard1, 1);
      cycle();
      check_eq("x5_busy_clr", busy_o[5], 0);
      check_eq("x5_haz_clr", hazard1, 0);
      check_eq("x5_rf", tb_rf[5], 32'hDEADBEEF);

      // WAW: second reservation of x7 is refused; x0 reserves freely
      rsv_valid = 1; rsv_addr = 7; cycle();
      check_eq("x7_set", busy_o[7], 1);
      #1 check_eq("x7_again", rsv_ok, 0);
      cycle();
      check_eq("x7_hold", busy_o[7], 1);
      rsv_addr = 0; saved_busy = busy_o;
      #1 check_eq("x0_rsv_ok", rsv_ok, 1);
      cycle();
      check_eq("x0_no_busy", busy_o, saved_busy);
      rsv_valid = 0;

      // Write to x0 is accepted and dropped
      saved_busy = busy_o;
      present(2, 0, 32'h1234); cycle();
      check_eq("x0_gnt", last_g, 2);
      check_eq("x0_we", rf_we, 0);
      check_eq("x0_data", rf_wdata, 32'h1234);
      check_eq("x0_busy", busy_o, saved_busy);

      // Reset while a write to busy x9 sits in the output register
      rsv_valid = 1; rsv_addr = 9; cycle();
      rsv_valid = 0;
      present(0, 9, 32'h0BAD_F00D); cycle();
      check_eq("x9_inflight", rf_we, 1);
      check_eq("x9_busy", busy_o[9], 1);
      rst = 1; cycle();
      rst = 0;
      check_eq("x9_rst_we", rf_we, 0);
      check_eq("x9_rst_busy", busy_o, 0);
      for (int i = 0; i < NREQ; i++) present(i, REG_AW'(20 + i), 32'h200 + i);
      #1 check_eq("ptr_restart", req_ready, 3'b001);
      repeat (NREQ) cycle();

      // Random traffic
      auto_refill = 1;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) present_rand(i);
         end
         rsv_valid = 1'($urandom_range(0, 1));
         rsv_addr  = REG_AW'($urandom_range(0, 7));
         chk_addr1 = REG_AW'($urandom_range(0, 7));
         chk_addr2 = REG_AW'($urandom_range(0, 31));
         rst       = ($urandom_range(0, 49) == 0);
         cycle();
      end
      rst = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
